// File: rtl/atod_sampler.sv
// atod_sampler: sample-strobe generator and capture averager for a dual-channel sin/cos A/D
module atod_sampler #(
  parameter int SMPL_PERIOD = 64,
  parameter int SMPL_HIGH = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic [11:0] ana_sin,
  input  logic [11:0] ana_cos,
  output logic smpl,
  output logic [11:0] sin_avg,
  output logic [11:0] cos_avg,
  output logic rdy,
  output logic [(AVG_LOG2 > 0 ? AVG_LOG2 : 1)-1:0] smp_cnt
);
  localparam int PW = $clog2(SMPL_PERIOD);
  localparam int CW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam int AW = 12 + AVG_LOG2;
  localparam int NAVG = 1 << AVG_LOG2;
  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;
  state_t state, nxt;
  logic [PW-1:0] pcnt;
  logic [CW-1:0] ccnt;
  logic [AW-1:0] acc_s, acc_c, sum_s, sum_c;
  logic cap, last, clr;
  assign smp_cnt = ccnt;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // slot sequencing: strobe phase, gap phase, abort to idle whenever en drops
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE: nxt = en ? HIGH : IDLE;
      HIGH: nxt = !en ? IDLE : (pcnt == PW'(SMPL_HIGH - 1)) ? GAP : HIGH;
      GAP: nxt = !en ? IDLE : (pcnt == PW'(SMPL_PERIOD - 1)) ? HIGH : GAP;
      default: nxt = IDLE;
    endcase
  end
  // capture happens on the edge that drops smpl, using the pre-edge converter word
  always_comb begin
    cap = state == HIGH && nxt == GAP;
    last = ccnt == CW'(NAVG - 1);
    clr = nxt == IDLE || (cap && last);
    sum_s = acc_s + AW'(ana_sin);
    sum_c = acc_c + AW'(ana_cos);
  end
  // counters, accumulators and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      smpl <= 1'b0;
      pcnt <= '0;
      ccnt <= '0;
      acc_s <= '0;
      acc_c <= '0;
      sin_avg <= '0;
      cos_avg <= '0;
      rdy <= 1'b0;
    end else begin
      smpl <= nxt == HIGH;
      pcnt <= (nxt == GAP || (state == HIGH && nxt == HIGH)) ? pcnt + PW'(1) : '0;
      rdy <= cap && last;
      ccnt <= clr ? '0 : cap ? ccnt + CW'(1) : ccnt;
      acc_s <= clr ? '0 : cap ? sum_s : acc_s;
      acc_c <= clr ? '0 : cap ? sum_c : acc_c;
      if (cap && last) begin
        sin_avg <= 12'(sum_s >> AVG_LOG2);
        cos_avg <= 12'(sum_c >> AVG_LOG2);
      end
    end
endmodule

// File: tb/tb_atod_sampler.sv
// tb_atod_sampler: scoreboard bench for atod_sampler (default config and a 3/1/0 config)
module tb_atod_sampler;
  logic clk = 0;
  logic rst_n = 0;
  logic en = 0, en2 = 0;
  logic [11:0] sin1, cos1, sin2, cos2;
  logic smpl, rdy, smpl2, rdy2;
  logic [11:0] sin_avg, cos_avg, sin_avg2, cos_avg2;
  logic [1:0] smp_cnt;
  logic smp_cnt2;
  int tests = 0, fails = 0;
  logic [11:0] st[16], ct[16], t2[16];
  logic [3:0] cidx = 0, cidx2 = 0;
  logic [23:0] q1[$], q2[$];
  logic [23:0] e1, e2;
  logic tchk = 0, ps = 0, have_rise = 0, have_rdy = 0, have2 = 0;
  int hi_len = 0, gap = 0, rgap = 0, ecnt = 0, cyc2 = 0, last2 = 0;

  always #10 clk = ~clk;

  atod_sampler dut (.clk(clk), .rst_n(rst_n), .en(en), .ana_sin(sin1), .ana_cos(cos1),
    .smpl(smpl), .sin_avg(sin_avg), .cos_avg(cos_avg), .rdy(rdy), .smp_cnt(smp_cnt));
  atod_sampler #(.SMPL_PERIOD(3), .SMPL_HIGH(1), .AVG_LOG2(0)) dut2 (.clk(clk), .rst_n(rst_n),
    .en(en2), .ana_sin(sin2), .ana_cos(cos2), .smpl(smpl2), .sin_avg(sin_avg2),
    .cos_avg(cos_avg2), .rdy(rdy2), .smp_cnt(smp_cnt2));

  assign sin1 = st[cidx];
  assign cos1 = ct[cidx];
  assign sin2 = t2[cidx2];
  assign cos2 = ~t2[cidx2];

  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // converter models: advance some time after each smpl falling edge
  always @(negedge smpl) if (rst_n) begin #10; cidx = cidx + 1; end
  always @(negedge smpl2) if (rst_n) begin #5; cidx2 = cidx2 + 1; end

  // scoreboard monitors
  always @(negedge clk) if (rst_n && rdy) begin
    if (q1.size() == 0) chk("rdy1_unexpected", 1, 0);
    else begin
      e1 = q1.pop_front();
      chk("sin_avg", sin_avg, e1[23:12]);
      chk("cos_avg", cos_avg, e1[11:0]);
    end
    chk("rdy1_smpl_low", smpl, 0);
  end
  always @(negedge clk) begin
    cyc2++;
    if (rst_n && rdy2) begin
      if (have2) chk("rdy2_gap", cyc2 - last2, 3);
      last2 = cyc2;
      have2 = 1;
      chk("rdy2_smpl_low", smpl2, 0);
      if (q2.size() == 0) chk("rdy2_unexpected", 1, 0);
      else begin
        e2 = q2.pop_front();
        chk("sin_avg2", sin_avg2, e2[23:12]);
        chk("cos_avg2", cos_avg2, e2[11:0]);
      end
    end
  end

  // slot timing checker for steady sampling
  always @(negedge clk) begin
    if (tchk) begin
      gap++;
      rgap++;
      if (smpl) hi_len++;
      if (smpl && !ps) begin
        if (have_rise) chk("rise_spacing", gap, 64);
        have_rise = 1;
        gap = 0;
      end
      if (!smpl && ps) begin
        chk("smpl_high_len", hi_len, 8);
        hi_len = 0;
        ecnt = (ecnt + 1) % 4;
        chk("smp_cnt_seq", smp_cnt, ecnt);
      end
      if (rdy) begin
        if (have_rdy) chk("rdy_spacing", rgap, 256);
        chk("rdy_first_low", ps, 1);
        have_rdy = 1;
        rgap = 0;
      end
    end
    ps = smpl;
  end

  initial begin
    #200000;
    chk("timeout", 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    st = '{12'h100, 12'h101, 12'h102, 12'h103, 12'h000, 12'h001, 12'h002, 12'h003,
           12'hAAA, 12'hAAA, 12'h010, 12'h020, 12'h030, 12'h040, 12'h777, 12'h777};
    ct = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h800, 12'h800, 12'h800, 12'h7FF,
           12'h555, 12'h555, 12'h003, 12'h003, 12'h003, 12'h003, 12'h777, 12'h777};
    for (int j = 0; j < 16; j++) t2[j] = 12'(j * 273 + 5);
    q1.push_back({12'h101, 12'hFFF});
    q1.push_back({12'h001, 12'h7FF});
    q1.push_back({12'h028, 12'h003});
    for (int j = 0; j < 10; j++) q2.push_back({t2[j], ~t2[j]});
    repeat (3) @(negedge clk);
    chk("reset_smpl", smpl, 0);
    chk("reset_smp_cnt", smp_cnt, 0);
    rst_n = 1;
    @(negedge clk);
    en = 1;
    tchk = 1;
    #1 chk("start_smpl_pre", smpl, 0);
    @(negedge clk);
    chk("start_smpl_rise", smpl, 1);
    repeat (8) @(negedge smpl);
    tchk = 0;
    repeat (2) @(negedge smpl);
    repeat (5) @(negedge clk);
    chk("abort_cnt_pre", smp_cnt, 2);
    en = 0;
    repeat (20) @(negedge clk);
    chk("abort_smpl", smpl, 0);
    chk("abort_cnt", smp_cnt, 0);
    chk("abort_sin_hold", sin_avg, 12'h001);
    chk("abort_cos_hold", cos_avg, 12'h7FF);
    en = 1;
    while (q1.size() != 0) @(negedge clk);
    @(negedge smpl);
    @(posedge smpl);
    repeat (3) @(negedge clk);
    chk("pre_rst_smp_cnt", smp_cnt, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_smpl", smpl, 0);
    chk("arst_rdy", rdy, 0);
    chk("arst_sin_avg", sin_avg, 0);
    chk("arst_cos_avg", cos_avg, 0);
    chk("arst_smp_cnt", smp_cnt, 0);
    @(negedge clk);
    chk("arst_hold_smpl", smpl, 0);
    rst_n = 1;
    #1 chk("rel_smpl_pre", smpl, 0);
    @(negedge clk);
    chk("rel_smpl_rise", smpl, 1);
    en = 0;
    repeat (5) @(negedge clk);
    en2 = 1;
    while (q2.size() != 0) @(negedge clk);
    en2 = 0;
    repeat (5) @(negedge clk);
    chk("q1_empty", q1.size(), 0);
    chk("q2_empty", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
